hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed 5-stage hazard/forwarding logic in the CPU pipeline.
- Keeps a per-register scoreboard of in-flight writes and issues stalls, flushes and registered forwarding selectors from it.
- Supports a configurable pipeline depth after Decode and per-instruction result-ready stage, so multi-cycle units plug in without rewriting hazard logic.
- Sits beside Decode; its outputs drive the Fetch/Decode/Execute pipeline registers and the Execute forwarding muxes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_lookup.sv | 30 +++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Scoreboard fields are sized for PIPEDEPTH up to 16.
package hazard_pkg;

   localparam int unsigned AGEW        = 5;
   localparam int unsigned SEL_REGFILE = 0;
   localparam int unsigned STAGE_E     = 0;

   typedef struct packed {
      logic            pend;
      logic [AGEW-1:0] age;
      logic [AGEW-1:0] rdy;
   } sb_entry_t;

   function automatic int unsigned sel_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/hazard_lookup.sv
// Per-source hazard detection and forwarding selector from one scoreboard entry.
module hazard_lookup
   import hazard_pkg::*;
#(
   parameter int unsigned PIPEDEPTH = 3,
   parameter int unsigned SELW      = 2
) (
   input  logic            used,
   input  sb_entry_t       entry,
   output logic            hazard,
   output logic [SELW-1:0] sel
);

   logic [AGEW:0] next_age;

   always_comb begin
      hazard   = 1'b0;
      sel      = SELW'(SEL_REGFILE);
      next_age = {1'b0, entry.age} + (AGEW+1)'(1);
      if (used && entry.pend) begin
         if (next_age < {1'b0, entry.rdy}) begin
            hazard = 1'b1;
         end else if (next_age < (AGEW+1)'(PIPEDEPTH)) begin
            sel = SELW'(next_age);
         end
         // A producer in WB this cycle has already written the register file.
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-driven stall/flush/forwarding control for a PIPEDEPTH-stage back end.
// Define HAZARD_ZERO_REG_EN to hardwire register 0 to zero.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 4,
   parameter int unsigned REGNUM       = 16,
   parameter int unsigned PIPEDEPTH    = 3,
   parameter int unsigned SELW         = sel_width(PIPEDEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    validD,
   input  logic                    writesD,
   input  logic [ADDRESSWIDTH-1:0] destD,
   input  logic [SELW-1:0]         readyStageD,
   input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
   input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
   input  logic                    reg1UsedD,
   input  logic                    reg2UsedD,
   input  logic                    takeBranchE,
   output logic                    stallF,
   output logic                    stallD,
   output logic                    flushD,
   output logic                    flushE,
   output logic [SELW-1:0]         data1ForwardSelectorE,
   output logic [SELW-1:0]         data2ForwardSelectorE,
   output logic                    pendingAny
);

   sb_entry_t       table_q [REGNUM];
   sb_entry_t       entry1, entry2;
   logic            used1, used2, record;
   logic            hazard1, hazard2, stall, issue;
   logic [SELW-1:0] sel1, sel2;
   logic [AGEW-1:0] rdy_clamped;

   function automatic logic in_range(input logic [ADDRESSWIDTH-1:0] a);
      return {1'b0, a} < (ADDRESSWIDTH+1)'(REGNUM);
   endfunction

`ifdef HAZARD_ZERO_REG_EN
   assign used1  = reg1UsedD && in_range(reg1AddressD) && (reg1AddressD != '0);
   assign used2  = reg2UsedD && in_range(reg2AddressD) && (reg2AddressD != '0);
   assign record = issue && writesD && in_range(destD) && (destD != '0);
`else
   assign used1  = reg1UsedD && in_range(reg1AddressD);
   assign used2  = reg2UsedD && in_range(reg2AddressD);
   assign record = issue && writesD && in_range(destD);
`endif

   assign entry1 = used1 ? table_q[reg1AddressD] : '0;
   assign entry2 = used2 ? table_q[reg2AddressD] : '0;

   hazard_lookup #(.PIPEDEPTH(PIPEDEPTH), .SELW(SELW)) u_lookup1 (
      .used(used1), .entry(entry1), .hazard(hazard1), .sel(sel1)
   );

   hazard_lookup #(.PIPEDEPTH(PIPEDEPTH), .SELW(SELW)) u_lookup2 (
      .used(used2), .entry(entry2), .hazard(hazard2), .sel(sel2)
   );

   assign stall  = validD && (hazard1 || hazard2) && !takeBranchE;
   assign issue  = validD && !stall && !takeBranchE;
   assign stallF = stall;
   assign stallD = stall;
   assign flushD = takeBranchE;
   assign flushE = stall || takeBranchE;

   always_comb begin
      rdy_clamped = AGEW'(readyStageD);
      if (readyStageD == '0 || AGEW'(readyStageD) >= AGEW'(PIPEDEPTH)) begin
         rdy_clamped = AGEW'(PIPEDEPTH - 1);
      end
   end

   // Aging is unconditional; a new record for destD overrides both aging and older producers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < REGNUM; i++) table_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < REGNUM; i++) begin
            if (table_q[i].pend) begin
               if (table_q[i].age == AGEW'(PIPEDEPTH - 1)) table_q[i].pend <= 1'b0;
               else table_q[i].age <= table_q[i].age + AGEW'(1);
            end
         end
         if (record) begin
            table_q[destD] <= '{pend: 1'b1, age: AGEW'(STAGE_E), rdy: rdy_clamped};
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data1ForwardSelectorE <= '0;
         data2ForwardSelectorE <= '0;
      end else if (issue) begin
         data1ForwardSelectorE <= sel1;
         data2ForwardSelectorE <= sel2;
      end else begin
         data1ForwardSelectorE <= '0;
         data2ForwardSelectorE <= '0;
      end
   end

   always_comb begin
      pendingAny = 1'b0;
      for (int unsigned i = 0; i < REGNUM; i++) pendingAny = pendingAny | table_q[i].pend;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (PIPEDEPTH=5); reference model tracks producers by issue cycle.
module tb_hazard_scoreboard;

   localparam int DEPTH = 5;
   localparam int NREG  = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       validD = 1'b0, writesD = 1'b0, takeBranchE = 1'b0;
   logic       reg1UsedD = 1'b0, reg2UsedD = 1'b0;
   logic [3:0] destD = '0, reg1AddressD = '0, reg2AddressD = '0;
   logic [2:0] readyStageD = '0;
   logic       stallF, stallD, flushD, flushE, pendingAny;
   logic [2:0] data1ForwardSelectorE, data2ForwardSelectorE;

   always #5 clock = ~clock;

   hazard_scoreboard #(.ADDRESSWIDTH(4), .REGNUM(NREG), .PIPEDEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .validD(validD), .writesD(writesD), .destD(destD),
      .readyStageD(readyStageD), .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
      .reg1UsedD(reg1UsedD), .reg2UsedD(reg2UsedD), .takeBranchE(takeBranchE),
      .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
      .data1ForwardSelectorE(data1ForwardSelectorE), .data2ForwardSelectorE(data2ForwardSelectorE),
      .pendingAny(pendingAny)
   );

   typedef struct {
      bit valid; bit writes; int dest; int rdy;
      int r1; bit u1; int r2; bit u2;
   } instr_t;

   typedef struct {
      int cyc; bit stall; bit flush_d; bit flush_e;
      int sel1; int sel2; bit pend_any;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: youngest producer per register, remembered by issue cycle.
   bit m_valid[NREG];
   int m_issue[NREG];
   int m_rdy[NREG];
   int m_sel1 = 0, m_sel2 = 0;
   int cyc = 0;

   function automatic void model_clear();
      for (int i = 0; i < NREG; i++) m_valid[i] = 1'b0;
      m_sel1 = 0;
      m_sel2 = 0;
   endfunction

   function automatic bit zero_reg(input int r);
`ifdef HAZARD_ZERO_REG_EN
      return r == 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void lookup(input int r, input bit used, output bit haz, output int sel);
      int d;
      haz = 1'b0;
      sel = 0;
      if (!used || zero_reg(r) || !m_valid[r]) return;
      d = cyc - m_issue[r];
      if (d > DEPTH) return;
      if (d < m_rdy[r]) haz = 1'b1;
      else if (d < DEPTH) sel = d;
   endfunction

   function automatic bit model_pend_any();
      for (int i = 0; i < NREG; i++)
         if (m_valid[i] && (cyc - m_issue[i]) >= 1 && (cyc - m_issue[i]) <= DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic instr_t mk(input bit v, input bit w, input int dst, input int rdy,
                                 input int a, input bit ua, input int b, input bit ub);
      instr_t t;
      t.valid = v; t.writes = w; t.dest = dst; t.rdy = rdy;
      t.r1 = a; t.u1 = ua; t.r2 = b; t.u2 = ub;
      return t;
   endfunction

   // mode: 0 normal (reset released), 1 assert reset mid-cycle, 2 hold reset
   task automatic step(input instr_t in, input bit br, input int mode, output bit stalled);
      bit   h1, h2, st, iss;
      int   s1, s2;
      exp_t e;
      @(posedge clock);
      #1;
      if (mode == 0) reset = 1'b0;
      validD       = in.valid;
      writesD      = in.writes;
      destD        = 4'(in.dest);
      readyStageD  = 3'(in.rdy);
      reg1AddressD = 4'(in.r1);
      reg1UsedD    = in.u1;
      reg2AddressD = 4'(in.r2);
      reg2UsedD    = in.u2;
      takeBranchE  = br;
      if (mode == 1) begin
         #2;
         reset = 1'b1;
      end
      if (mode != 0) model_clear();
      lookup(in.r1, in.u1, h1, s1);
      lookup(in.r2, in.u2, h2, s2);
      st = in.valid && (h1 || h2) && !br;
      e.cyc = cyc; e.stall = st; e.flush_d = br; e.flush_e = st || br;
      e.sel1 = m_sel1; e.sel2 = m_sel2; e.pend_any = model_pend_any();
      q.push_back(e);
      if (mode == 0) begin
         iss = in.valid && !st && !br;
         if (iss && in.writes && !zero_reg(in.dest)) begin
            m_valid[in.dest] = 1'b1;
            m_issue[in.dest] = cyc;
            m_rdy[in.dest]   = (in.rdy == 0 || in.rdy >= DEPTH) ? DEPTH - 1 : in.rdy;
         end
         m_sel1 = iss ? s1 : 0;
         m_sel2 = iss ? s2 : 0;
      end
      cyc++;
      stalled = st;
   endtask

   task automatic run(input instr_t in, input bit br);
      bit st;
      for (int n = 0; n < 2 * DEPTH + 2; n++) begin
         step(in, br, 0, st);
         if (!st) break;
      end
   endtask

   task automatic drain(input int n);
      bit st;
      for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0, st);
   endtask

   task automatic chk(input string name, input int act, input int exp, input int c);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         while (q.size() != 0) begin
            e = q.pop_front();
            chk("stallF", int'(stallF), int'(e.stall), e.cyc);
            chk("stallD", int'(stallD), int'(e.stall), e.cyc);
            chk("flushD", int'(flushD), int'(e.flush_d), e.cyc);
            chk("flushE", int'(flushE), int'(e.flush_e), e.cyc);
            chk("sel1", int'(data1ForwardSelectorE), e.sel1, e.cyc);
            chk("sel2", int'(data2ForwardSelectorE), e.sel2, e.cyc);
            chk("pendingAny", int'(pendingAny), int'(e.pend_any), e.cyc);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bit st;
      instr_t t;
      bit br;
      model_clear();
      repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 2, st);

      // back-to-back ALU dependency
      run(mk(1, 1, 1, 1, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 2, 1, 1, 1, 3, 1), 1'b0);
      drain(7);
      // load-use, then load with one-instruction gap
      run(mk(1, 1, 4, 2, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 4, 1, 0, 0), 1'b0);
      drain(7);
      run(mk(1, 1, 4, 2, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 8, 1, 9, 1, 10, 1), 1'b0);
      run(mk(1, 0, 0, 1, 0, 0, 4, 1), 1'b0);
      drain(7);
      // deep producer, then full drain to empty
      run(mk(1, 1, 6, 4, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 6, 1, 6, 1), 1'b0);
      drain(7);
      // overwrite: youngest producer wins
      run(mk(1, 1, 5, 2, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 5, 1, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 0, 0, 5, 1), 1'b0);
      drain(7);
      // taken branch hides hazard and drops the D instruction's write
      run(mk(1, 1, 7, 4, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 11, 4, 7, 1, 0, 0), 1'b1);
      run(mk(1, 0, 0, 1, 11, 1, 7, 1), 1'b0);
      drain(7);
      // ready-stage clamping
      run(mk(1, 1, 9, 0, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 9, 1, 0, 0), 1'b0);
      drain(7);
      run(mk(1, 1, 9, 7, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 9, 1, 0, 0), 1'b0);
      drain(7);
      // register 0 write then read
      run(mk(1, 1, 0, 2, 0, 0, 0, 0), 1'b0);
      run(mk(1, 0, 0, 1, 0, 1, 0, 1), 1'b0);
      drain(7);
      // async reset mid-stall with three pending entries
      run(mk(1, 1, 1, 4, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 2, 4, 0, 0, 0, 0), 1'b0);
      run(mk(1, 1, 3, 4, 0, 0, 0, 0), 1'b0);
      step(mk(1, 0, 0, 1, 3, 1, 0, 0), 1'b0, 1, st);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 2, st);

      for (int n = 0; n < 1200; n++) begin
         t.valid  = ($urandom_range(0, 9) != 0);
         t.writes = ($urandom_range(0, 9) < 7);
         t.dest   = $urandom_range(0, 5);
         t.rdy    = $urandom_range(0, 7);
         t.r1     = $urandom_range(0, 5);
         t.u1     = ($urandom_range(0, 3) != 0);
         t.r2     = $urandom_range(0, 5);
         t.u2     = ($urandom_range(0, 3) != 0);
         br       = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 299) == 0) begin
            step(t, br, 1, st);
            step(t, 1'b0, 2, st);
         end else begin
            run(t, br);
         end
      end
      drain(8);
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
